// File: rtl/jtopl_wrsched_if.sv
// Write-scheduler bus bundle: two requester write ports, the clock enable and the
// chip-side write port of jtopl_wrsched.
//   master : requester/chip-side environment (drives cen, req*, reg*, val*)
//   slave  : the scheduler (drives ack*, write, addr, dout, busy)
interface jtopl_wrsched_if;
  logic       cen;
  logic       req0;
  logic [7:0] reg0;
  logic [7:0] val0;
  logic       ack0;
  logic       req1;
  logic [7:0] reg1;
  logic [7:0] val1;
  logic       ack1;
  logic       write;
  logic       addr;
  logic [7:0] dout;
  logic       busy;

  modport master (
    output cen, req0, reg0, val0, req1, reg1, val1,
    input  ack0, ack1, write, addr, dout, busy
  );

  modport slave (
    input  cen, req0, reg0, val0, req1, reg1, val1,
    output ack0, ack1, write, addr, dout, busy
  );
endinterface

// File: rtl/jtopl_wrsched.sv
// Register-write scheduler for an OPL-style chip port. Two requesters are
// arbitrated round-robin; each accepted transaction issues an address-port write
// (skipped when the register number matches the last one written), waits WAIT_ADR
// cen ticks, issues a data-port write and waits WAIT_DAT cen ticks before the
// next grant.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of jtopl_wrsched_if (cen, req/reg/val/ack x2,
//              write/addr/dout chip port, busy)
module jtopl_wrsched #(
  parameter int unsigned WAIT_ADR = 12,
  parameter int unsigned WAIT_DAT = 84
) (
  input logic            clk,
  input logic            rst,
  jtopl_wrsched_if.slave bus
);

  localparam logic [7:0] WaitAdr = 8'(WAIT_ADR);
  localparam logic [7:0] WaitDat = 8'(WAIT_DAT);

  typedef enum logic [2:0] {StIdle, StAdr, StWadr, StDat, StWdat} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       last_gnt_q, last_gnt_d;
  logic       skip_ok_q, skip_ok_d;
  logic [7:0] last_reg_q, last_reg_d;
  logic [7:0] lat_reg_q, lat_reg_d;
  logic [7:0] lat_val_q, lat_val_d;
  logic       write_q, write_d;
  logic       addr_q, addr_d;
  logic [7:0] dout_q, dout_d;
  logic       ack0, ack1, gnt1;
  logic [7:0] sel_reg, sel_val;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    skip_ok_d  = skip_ok_q;
    last_reg_d = last_reg_q;
    lat_reg_d  = lat_reg_q;
    lat_val_d  = lat_val_q;
    write_d    = 1'b0;
    addr_d     = addr_q;
    dout_d     = dout_q;
    ack0       = 1'b0;
    ack1       = 1'b0;
    gnt1       = 1'b0;
    sel_reg    = bus.reg0;
    sel_val    = bus.val0;

    unique case (state_q)
      StIdle: begin
        // Ack is suppressed during reset so an aborted cycle never accepts a request.
        if (!rst && (bus.req0 || bus.req1)) begin
          gnt1       = bus.req1 && (!bus.req0 || !last_gnt_q);
          sel_reg    = gnt1 ? bus.reg1 : bus.reg0;
          sel_val    = gnt1 ? bus.val1 : bus.val0;
          ack0       = !gnt1;
          ack1       = gnt1;
          last_gnt_d = gnt1;
          lat_reg_d  = sel_reg;
          lat_val_d  = sel_val;
          // Outputs are registered, so the strobe for the next state is set up here.
          write_d    = 1'b1;
          if (skip_ok_q && (sel_reg == last_reg_q)) begin
            state_d = StDat;
            addr_d  = 1'b1;
            dout_d  = sel_val;
          end else begin
            state_d = StAdr;
            addr_d  = 1'b0;
            dout_d  = sel_reg;
          end
        end
      end
      StAdr: begin
        last_reg_d = lat_reg_q;
        skip_ok_d  = 1'b1;
        cnt_d      = WaitAdr;
        state_d    = StWadr;
      end
      StWadr: begin
        if (cnt_q == 8'd0) begin
          state_d = StDat;
          write_d = 1'b1;
          addr_d  = 1'b1;
          dout_d  = lat_val_q;
        end else if (bus.cen) begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StDat: begin
        cnt_d   = WaitDat;
        state_d = StWdat;
      end
      StWdat: begin
        if (cnt_q == 8'd0) begin
          state_d = StIdle;
        end else if (bus.cen) begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      last_gnt_q <= 1'b1;  // requester 0 wins the first contention
      skip_ok_q  <= 1'b0;
      last_reg_q <= 8'd0;
      lat_reg_q  <= 8'd0;
      lat_val_q  <= 8'd0;
      write_q    <= 1'b0;
      addr_q     <= 1'b0;
      dout_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      skip_ok_q  <= skip_ok_d;
      last_reg_q <= last_reg_d;
      lat_reg_q  <= lat_reg_d;
      lat_val_q  <= lat_val_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
    end
  end

  assign bus.ack0  = ack0;
  assign bus.ack1  = ack1;
  assign bus.write = write_q;
  assign bus.addr  = addr_q;
  assign bus.dout  = dout_q;
  assign bus.busy  = (state_q != StIdle);

endmodule

// File: tb/tb_jtopl_wrsched.sv
// Self-checking bench for jtopl_wrsched. A transaction-level model computes, at
// each grant, the cycles of the address and data writes and of the return to idle
// from the pre-generated cen sequence; every cycle all outputs are compared.
module tb_jtopl_wrsched;
  localparam int WA = 2;
  localparam int WD = 3;
  localparam int NCYC = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtopl_wrsched_if bus ();
  jtopl_wrsched_if bz ();

  jtopl_wrsched #(.WAIT_ADR(WA), .WAIT_DAT(WD)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  jtopl_wrsched #(.WAIT_ADR(0), .WAIT_DAT(0)) dut_z (
    .clk(clk), .rst(rst), .bus(bz.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit cen_tab [0:NCYC-1];

  // stimulus state
  logic       r0 = 0, r1 = 0, rst_v = 1;
  logic [7:0] g0 = 0, g1 = 0, v0 = 0, v1 = 0;
  logic       zr = 0;
  logic [7:0] zg = 0, zv = 0;
  int p_raise0 = 20, p_raise1 = 20, p_keep0 = 25, p_keep1 = 25, p_drop = 2;

  // observations from the last cycle
  logic ack_seen0 = 0, ack_seen1 = 0, busy_seen = 0, wr_seen = 0, addr_seen = 0;
  logic [7:0] dout_seen = 0;
  int na0 = 0, na1 = 0;
  logic       zw [0:NCYC-1];
  logic       za [0:NCYC-1];
  logic       zb [0:NCYC-1];
  logic       zk0 [0:NCYC-1];
  logic       zk1 [0:NCYC-1];
  logic [7:0] zd [0:NCYC-1];

  // reference model state
  int m_adr_t = -1, m_dat_t = -1, m_idle_t = 0;
  logic m_last = 1, m_skip = 0, m_haddr = 0;
  logic [7:0] m_lreg = 0, m_reg = 0, m_val = 0, m_hdout = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // First cycle at which the state after a wait starting at cycle s begins.
  function automatic int wait_end(input int s, input int n);
    int k = 0;
    if (n == 0) return s + 1;
    for (int c = s; c < NCYC; c++) begin
      if (cen_tab[c]) k++;
      if (k == n) return c + 2;
    end
    return NCYC + 1;
  endfunction

  task automatic tick();
    logic eg0, eg1, ew, ebusy;
    bus.cen = cen_tab[cyc];
    bus.req0 = r0; bus.reg0 = g0; bus.val0 = v0;
    bus.req1 = r1; bus.reg1 = g1; bus.val1 = v1;
    bz.cen = 1'b0;
    bz.req0 = zr; bz.reg0 = zg; bz.val0 = zv;
    bz.req1 = 1'b0; bz.reg1 = 8'd0; bz.val1 = 8'd0;
    rst = rst_v;
    @(negedge clk);
    ew = (cyc == m_adr_t) || (cyc == m_dat_t);
    if (cyc == m_adr_t) begin m_haddr = 1'b0; m_hdout = m_reg; end
    if (cyc == m_dat_t) begin m_haddr = 1'b1; m_hdout = m_val; end
    ebusy = cyc < m_idle_t;
    eg0 = 1'b0; eg1 = 1'b0;
    if (!rst_v && cyc >= m_idle_t && (r0 || r1)) begin
      eg1 = (r0 && r1) ? (m_last == 1'b0) : r1;
      eg0 = !eg1;
    end
    check_eq("ack0", bus.ack0, eg0);
    check_eq("ack1", bus.ack1, eg1);
    check_eq("write", bus.write, ew);
    check_eq("addr", bus.addr, m_haddr);
    check_eq("dout", bus.dout, m_hdout);
    check_eq("busy", bus.busy, ebusy);
    if (eg0 || eg1) begin
      m_reg  = eg1 ? g1 : g0;
      m_val  = eg1 ? v1 : v0;
      m_last = eg1;
      if (m_skip && m_reg == m_lreg) begin
        m_adr_t = -1;
        m_dat_t = cyc + 1;
      end else begin
        m_adr_t = cyc + 1;
        m_dat_t = wait_end(cyc + 2, WA);
        m_skip  = 1'b1;
        m_lreg  = m_reg;
      end
      m_idle_t = wait_end(m_dat_t + 1, WD);
    end
    if (rst_v) begin
      m_adr_t = -1; m_dat_t = -1; m_idle_t = cyc + 1;
      m_haddr = 1'b0; m_hdout = 8'd0;
      m_skip = 1'b0; m_lreg = 8'd0; m_last = 1'b1;
    end
    ack_seen0 = bus.ack0; ack_seen1 = bus.ack1; busy_seen = bus.busy;
    wr_seen = bus.write; addr_seen = bus.addr; dout_seen = bus.dout;
    if (bus.ack0) na0++;
    if (bus.ack1) na1++;
    zw[cyc] = bz.write; za[cyc] = bz.addr; zd[cyc] = bz.dout; zb[cyc] = bz.busy;
    zk0[cyc] = bz.ack0; zk1[cyc] = bz.ack1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_ack(input int which);
    for (int b = 0; b < 200; b++) begin
      tick();
      if ((which == 0 && ack_seen0) || (which == 1 && ack_seen1)) return;
    end
    check_eq("ack_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int b = 0; b < 200; b++) begin
      tick();
      if (!busy_seen) return;
    end
    check_eq("idle_timeout", 0, 1);
  endtask

  task automatic gen_reqs();
    if (r0) begin
      if (ack_seen0) begin
        if ($urandom_range(0, 99) < p_keep0) begin
          g0 = 8'($urandom_range(0, 3)); v0 = 8'($urandom);
        end else r0 = 1'b0;
      end else if ($urandom_range(0, 99) < p_drop) r0 = 1'b0;
    end else if ($urandom_range(0, 99) < p_raise0) begin
      r0 = 1'b1; g0 = 8'($urandom_range(0, 3)); v0 = 8'($urandom);
    end
    if (r1) begin
      if (ack_seen1) begin
        if ($urandom_range(0, 99) < p_keep1) begin
          g1 = 8'($urandom_range(0, 3)); v1 = 8'($urandom);
        end else r1 = 1'b0;
      end else if ($urandom_range(0, 99) < p_drop) r1 = 1'b0;
    end else if ($urandom_range(0, 99) < p_raise1) begin
      r1 = 1'b1; g1 = 8'($urandom_range(0, 3)); v1 = 8'($urandom);
    end
  endtask

  // Checks one WAIT=0 transaction on dut_z granted at cycle b.
  task automatic check_z(input int b, input logic skip, input logic [7:0] rg,
                         input logic [7:0] vl);
    check_eq("z_ack0", zk0[b], 1);
    check_eq("z_ack1", zk1[b], 0);
    check_eq("z_busy_grant", zb[b], 0);
    if (skip) begin
      check_eq("z_dat_wr", zw[b+1], 1);
      check_eq("z_dat_addr", za[b+1], 1);
      check_eq("z_dat_dout", zd[b+1], vl);
      check_eq("z_wdat_wr", zw[b+2], 0);
      check_eq("z_idle", zb[b+3], 0);
    end else begin
      check_eq("z_adr_wr", zw[b+1], 1);
      check_eq("z_adr_addr", za[b+1], 0);
      check_eq("z_adr_dout", zd[b+1], rg);
      check_eq("z_wadr_wr", zw[b+2], 0);
      check_eq("z_wadr_busy", zb[b+2], 1);
      check_eq("z_dat_wr", zw[b+3], 1);
      check_eq("z_dat_addr", za[b+3], 1);
      check_eq("z_dat_dout", zd[b+3], vl);
      check_eq("z_wdat_busy", zb[b+4], 1);
      check_eq("z_idle", zb[b+5], 0);
    end
  endtask

  initial begin
    int n_aw, n_dw, s, b0, b1;
    for (int i = 0; i < NCYC; i++)
      cen_tab[i] = (i < 400) ? bit'(i % 2 == 1) : bit'($urandom_range(0, 1));
    bus.cen = 0; bus.req0 = 0; bus.reg0 = 0; bus.val0 = 0;
    bus.req1 = 0; bus.reg1 = 0; bus.val1 = 0;
    bz.cen = 0; bz.req0 = 0; bz.reg0 = 0; bz.val0 = 0;
    bz.req1 = 0; bz.reg1 = 0; bz.val1 = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_v = 1'b0;
    tick();  // reset state

    // Contention right after reset: requester 0 first, then 1.
    r0 = 1; g0 = 8'h02; v0 = 8'h80;
    r1 = 1; g1 = 8'h04; v1 = 8'h01;
    wait_ack(0);
    check_eq("first_grant_is_0", ack_seen1, 0);
    r0 = 0;
    wait_ack(1);
    r1 = 0;
    wait_idle();

    // Same register again: data write only.
    r1 = 1; g1 = 8'h04; v1 = 8'h80;
    wait_ack(1);
    r1 = 0;
    n_aw = 0; n_dw = 0;
    for (int b = 0; b < 200; b++) begin
      tick();
      if (wr_seen && !addr_seen) n_aw++;
      if (wr_seen && addr_seen && dout_seen == 8'h80) n_dw++;
      if (!busy_seen) break;
    end
    check_eq("skip_adr_writes", n_aw, 0);
    check_eq("skip_dat_writes", n_dw, 1);

    // Reset in the address wait aborts the transaction and clears the skip state.
    r0 = 1; g0 = 8'h05; v0 = 8'h5a;
    wait_ack(0);
    r0 = 0;
    tick();
    tick();
    rst_v = 1;
    tick();
    rst_v = 0;
    n_dw = 0;
    for (int b = 0; b < 10; b++) begin
      tick();
      if (wr_seen) n_dw++;
    end
    check_eq("no_write_after_rst", n_dw, 0);
    r0 = 1; g0 = 8'h05; v0 = 8'h5b;
    wait_ack(0);
    r0 = 0;
    tick();
    check_eq("adr_after_rst_wr", wr_seen, 1);
    check_eq("adr_after_rst_addr", addr_seen, 0);
    wait_idle();

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      gen_reqs();
      rst_v = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst_v = 0; r0 = 0; r1 = 0;
    wait_idle();

    // Requester 0 always asserting; requester 1 pulsing.
    p_raise0 = 100; p_keep0 = 100; p_raise1 = 50; p_keep1 = 0; p_drop = 0;
    b0 = na0; b1 = na1;
    for (int i = 0; i < 300; i++) begin
      gen_reqs();
      tick();
    end
    check_eq("no_starve0", (na0 - b0) > 5, 1);
    check_eq("no_starve1", (na1 - b1) > 5, 1);
    r0 = 0; r1 = 0;
    wait_idle();

    // WAIT=0 instance with cen held low.
    s = cyc; zr = 1; zg = 8'h11; zv = 8'h22;
    tick(); zr = 0;
    repeat (4) tick();
    b0 = cyc; zr = 1; zg = 8'h33; zv = 8'h44;
    tick(); zr = 0;
    repeat (5) tick();
    b1 = cyc; zr = 1; zg = 8'h33; zv = 8'h55;
    tick(); zr = 0;
    repeat (4) tick();
    check_z(s, 1'b0, 8'h11, 8'h22);
    check_z(b0, 1'b0, 8'h33, 8'h44);
    check_z(b1, 1'b1, 8'h33, 8'h55);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/jtopl_wrsched.md
JTOPL_WRSCHED -- requirements
Module: jtopl_wrsched

Interface
REQ-001 Parameter WAIT_ADR, default 12: cen ticks to wait after an address-port write, 0..255.
REQ-002 Parameter WAIT_DAT, default 84: cen ticks to wait after a data-port write, 0..255.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cen  input  1  clock enable; wait counters advance only on cycles with cen=1.
REQ-006 req0  input  1  requester 0 write request; held high until ack0.
REQ-007 reg0  input  8  requester 0 target register number; stable while req0=1.
REQ-008 val0  input  8  requester 0 register value; stable while req0=1.
REQ-009 ack0  output  1  one-clk pulse: requester 0 transaction accepted.
REQ-010 req1, reg1, val1, ack1  same as req0/reg0/val0/ack0 for requester 1.
REQ-011 write  output  1  chip-side write strobe, one clk wide.
REQ-012 addr  output  1  chip-side port select: 0 = address port, 1 = data port.
REQ-013 dout  output  8  chip-side write data.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL use states IDLE, ADR, WADR, DAT, WDAT.
REQ-016 In IDLE with any req high, the block SHALL grant one requester, pulse its ack in that same clk, and latch its reg/val.
REQ-017 Arbitration SHALL be round-robin: if both req are high, grant the requester not granted last; if only one is high, grant it.
REQ-018 The last-granted pointer SHALL update only on a grant.
REQ-019 After a grant, if skip_ok=1 and the latched reg equals last_reg, go to DAT; otherwise go to ADR.
REQ-020 In ADR (one clk): write=1, addr=0, dout=latched reg; set last_reg=reg and skip_ok=1; go to WADR with cnt=WAIT_ADR.
REQ-021 In WADR: if cnt==0, go to DAT; otherwise decrement cnt on cen=1 and hold on cen=0.
REQ-022 In DAT (one clk): write=1, addr=1, dout=latched val; go to WDAT with cnt=WAIT_DAT.
REQ-023 In WDAT: if cnt==0, go to IDLE; otherwise decrement cnt on cen=1.
REQ-024 A new grant SHALL NOT occur before the IDLE cycle that follows WDAT, so back-to-back transactions are separated by at least one IDLE clk.
REQ-025 With WAIT_x=0, each wait state SHALL last exactly one clk.
REQ-026 With WAIT_x=N>0, each wait state SHALL last exactly until N cen pulses have occurred, then one more clk.
REQ-027 Outside ADR and DAT, write SHALL be 0.
REQ-028 dout and addr SHALL hold their last driven values while write=0.
REQ-029 cnt SHALL be 8 bits and SHALL never wrap: decrement only when nonzero.
REQ-030 At most one of ack0/ack1 SHALL be high in any clk.
REQ-031 A req dropped before its ack SHALL produce no transaction.
REQ-032 A req still high one clk after its ack SHALL be treated as a new request.
REQ-033 Two consecutive transactions to the same register SHALL issue only one address write.

Reset
REQ-034 rst SHALL abort any transaction immediately, with no further write or ack.
REQ-035 Reset values SHALL be: state=IDLE, write=0, addr=0, dout=0, ack0=ack1=0, busy=0, cnt=0, skip_ok=0, last_reg=0.
REQ-036 The last-granted pointer SHALL reset to 1, so requester 0 wins the first contention.

Verification
REQ-037 WAIT_ADR=2, WAIT_DAT=3, cen every 2nd clk; req0 with reg=0x02, val=0x80 -> ack0 at grant; write/addr=0/dout=0x02; after 2 cen, write/addr=1/dout=0x80; busy falls after 3 more cen.
REQ-038 req0 and req1 raised together after reset -> req0 is served first; req1 is granted in the first IDLE after; ack pulses never overlap.
REQ-039 Two req1 writes to reg 0x04 (values 0x01, then 0x80) -> the second transaction has no addr=0 write, only a data write of 0x80.
REQ-040 rst asserted during WADR -> no data write follows; all outputs return to reset values the next clk; the next request emits an address write (skip_ok cleared).
REQ-041 WAIT_ADR=0, WAIT_DAT=0, cen=0 constant -> each transaction completes in 5 clk (grant, ADR, WADR, DAT, WDAT).
REQ-042 req0 held high continuously while req1 pulses -> grants alternate 0,1,0,1; neither requester starves.
